// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// master = fetch stage (drives request + address), slave = instruction memory.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] PCF;
  logic        imem_ack;
  logic [31:0] InstrF;

  modport master (output imem_req, PCF, input imem_ack, InstrF);
  modport slave  (input imem_req, PCF, output imem_ack, InstrF);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, the imem request handshake (RUN/WAIT/DROP) and the
// F/D pipeline register. Optional perf counters under `ifdef FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         PCSrcW,
  input  logic [31:0]  ResultW,
  input  logic         BranchTakenE,
  input  logic [31:0]  ALUResultE,
  fetch_stage_if.master imem,
  output logic [31:0]  InstrD,
  output logic [31:0]  PCPlus8D,
  output logic         ValidD,
  output logic         FetchBusy
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  FetchCount,
  output logic [15:0]  BubbleCount
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t      state;
  logic [31:0] pc, pc_plus4, pc_plus8, target;
  logic        redirect, req, fetch_done, fd_load, fd_bubble;

  // Writeback redirect is older than the execute one, so it wins.
  assign redirect = PCSrcW | BranchTakenE;
  assign target   = PCSrcW ? ResultW : ALUResultE;
  assign pc_plus4 = pc + 32'd4;
  assign pc_plus8 = pc + 32'd8;

  // Request is live in RUN unless stalled, always in WAIT, never in DROP.
  always_comb begin
    req = 1'b0;
    case (state)
      RUN:     req = !StallF;
      WAIT:    req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  // DROP has req=0, so its stale ack never counts as a completed fetch.
  assign fetch_done    = req & imem.imem_ack;
  assign imem.imem_req = req & ~reset;
  assign imem.PCF      = pc;
  assign FetchBusy     = (state != RUN);

  // Redirect/flush bubble beats stall hold beats load; idle cycles bubble.
  assign fd_load   = !FlushD && !redirect && !StallD && fetch_done;
  assign fd_bubble = FlushD || redirect || (!StallD && !fetch_done);

  // PC and handshake FSM. An unanswered request that gets redirected moves
  // to DROP so its late response is swallowed rather than decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      if (redirect)                  pc <= target;
      else if (fetch_done && !StallF) pc <= pc_plus4;

      case (state)
        RUN:     if (req && !imem.imem_ack) state <= redirect ? DROP : WAIT;
        WAIT:    if (imem.imem_ack)         state <= RUN;
                 else if (redirect)         state <= DROP;
        DROP:    if (imem.imem_ack)         state <= RUN;
        default:                            state <= RUN;
      endcase
    end
  end

  // F/D register; PCPlus8D keeps its last value across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCPlus8D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (fd_load) begin
      InstrD   <= imem.InstrF;
      PCPlus8D <= pc_plus8;
      ValidD   <= 1'b1;
    end else if (fd_bubble) begin
      InstrD   <= NOP_INSTR;
      ValidD   <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counts of real instructions and bubbles written into D.
  always_ff @(posedge clk) begin
    if (reset) begin
      FetchCount  <= 16'd0;
      BubbleCount <= 16'd0;
    end else begin
      if (fd_load && FetchCount != 16'hFFFF)    FetchCount  <= FetchCount + 16'd1;
      if (fd_bubble && BubbleCount != 16'hFFFF) BubbleCount <= BubbleCount + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the pipelined ARM core, directly upstream of the pipelined control unit and datapath decode stage.
- Owns PCF and the instruction-memory request handshake, and drives the F/D pipeline register (InstrD, PCPlus8D, ValidD) that the decoder consumes.
- Applies PC redirects from the writeback-stage PCSrcW/ResultW and from an early execute-stage branch, plus the hazard unit's stall and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding driven on InstrD for bubbles (ANDEQ r0,r0,r0).

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PCF and suppress new request (hazard unit)
- StallD  in  1  hold F/D register contents
- FlushD  in  1  load bubble into F/D register
- PCSrcW  in  1  writeback redirect valid
- ResultW  in  32  writeback redirect target
- BranchTakenE  in  1  early execute redirect valid
- ALUResultE  in  32  execute redirect target
- imem_req  out  1  instruction fetch request
- PCF  out  32  fetch address
- imem_ack  in  1  InstrF valid this cycle
- InstrF  in  32  instruction read data
- InstrD  out  32  decode-stage instruction
- PCPlus8D  out  32  PC+8 of InstrD (ARM R15 read value)
- ValidD  out  1  InstrD is a real instruction
- FetchBusy  out  1  high in WAIT or DROP state

Behaviour:
- Reset values: PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus8D=0, ValidD=0, imem_req=0, state=RUN, FetchBusy=0. Reset overrides every other input.
- Arithmetic: PCPlus4F=PCF+4 and PCPlus8=PCF+8, both mod 2^32; 32'hFFFF_FFFC wraps to 0.
- FSM has three states: RUN, WAIT, DROP.
- RUN:
  - imem_req=!StallF.
  - ack=1: the fetch completes and PCF advances to PCPlus4F.
  - ack=0 with a request: go to WAIT, PCF holds.
- WAIT:
  - imem_req=1 and PCF holds.
  - ack returns to RUN and completes the fetch.
- Redirect while in WAIT with ack=0:
  - Load the target into PCF and go to DROP. The in-flight response is discarded.
- DROP:
  - imem_req=0.
  - The first ack is discarded and the FSM returns to RUN; the new PCF is requested next cycle.
  - A further redirect while in DROP updates PCF and stays in DROP.
- Next-PC priority: reset > PCSrcW (ResultW) > BranchTakenE (ALUResultE) > StallF/miss hold > PCPlus4F.
  - PCSrcW outranks BranchTakenE because the writeback instruction is older.
  - Redirects apply even when StallF=1.
- F/D register update priority: reset > FlushD or any redirect (bubble: InstrD=NOP_INSTR, ValidD=0, PCPlus8D unchanged) > StallD (hold) > completed fetch (InstrD=InstrF, PCPlus8D=PCF+8, ValidD=1) > no completed fetch (bubble).
- Latency: instruction at PCF is presented on InstrD one cycle after ack.
- Completed fetch with StallD=1 and StallF=0 is a protocol error; the hazard unit always raises both together. The bench asserts this never occurs.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs FetchCount[15:0] and BubbleCount[15:0].
  - FetchCount increments on each completed fetch loaded into D.
  - BubbleCount increments on each cycle ValidD is written 0.
  - Both counters saturate at 16'hFFFF, clear on reset, and are not affected by stalls.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, then ack=1 every cycle, InstrF=PCF.
  - Response: PCF 0,4,8,12. InstrD equals the prior PCF one cycle later, ValidD=1, PCPlus8D=8,12,16.
- Miss wait:
  - Stimulus: ack=0 for 3 cycles at PCF=0x10.
  - Response: FetchBusy=1, PCF holds 0x10, three bubbles. InstrD=mem[0x10] the cycle after ack.
- Simultaneous redirects:
  - Stimulus: PCSrcW=1/ResultW=0x100 and BranchTakenE=1/ALUResultE=0x200 in the same cycle.
  - Response: PCF=0x100 next cycle and ValidD=0.
- Redirect during WAIT:
  - Stimulus: miss at 0x20, then PCSrcW=1 to 0x80, then ack returns the stale word.
  - Response: the stale word never reaches InstrD. The next valid InstrD=mem[0x80].
- Stall/flush:
  - StallF=StallD=1 for 2 cycles: PCF and InstrD hold.
  - FlushD=1 with StallD=1: InstrD=NOP_INSTR and ValidD=0 (flush wins).
- Wrap and reset:
  - Stimulus: PCF=0xFFFF_FFFC with ack=1.
  - Response: PCF=0.
  - Reset asserted in WAIT returns PCF=RESET_PC and state=RUN next cycle.
